collision_responder: RTL and testbench
======================================

Name: collision_responder

Overview:
- Consumes the aggregated collision signals from the collision detector and turns them into game-state consequences: lives, score, immortality window, rope retraction and ball-split requests toward the ball spawner.
- Collision inputs are per-pixel levels that may assert many times per frame. This block latches them per frame and acts once per frame, at the startOfFrame pulse.
- Sits between the collision detector and the game controller / ball spawner.

Parameters:
- IMMORTAL_FRAMES, 120: frames of immortality after a player hit or a present pickup.
- LIVES_INIT, 3: lives loaded at reset.
- SCORE_W, 16: score counter width.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- col_player_ball  in  1  player overlaps any ball (level)
- col_rope_ball  in  1  rope overlaps a ball (level)
- col_ball_type  in  2  type of the ball hit by the rope; valid with col_rope_ball
- col_present  in  1  player overlaps a present (level)
- split_ack  in  1  spawner accepted the split request
- split_req  out  1  request to spawn two children of split_type
- split_type  out  2  child ball type
- rope_retract  out  1  one-cycle pulse: retract the rope
- score  out  SCORE_W  accumulated score
- lives  out  2  remaining lives
- immortal  out  1  immortality window active
- game_over  out  1  sticky; set when lives reaches 0

Behaviour:
- Reset values:
  - split_req=0, split_type=0, rope_retract=0, score=0.
  - lives=LIVES_INIT, immortal=0, game_over=0.
  - All sticky flags clear; FSM in S_RUN.
- Frame latch:
  - Sticky flags player_f, rope_f, present_f set on any cycle where the matching input is high.
  - rope_type_f captures col_ball_type on the first rope hit of the frame only; later hits in the same frame do not overwrite it.
  - An input asserted in the same cycle as startOfFrame belongs to the next frame: it sets the flag after the clear.
- Evaluation on startOfFrame in S_RUN, in this order:
  - Immortal counter: if nonzero, decrement by 1.
  - player_f && !immortal:
    - lives decremented.
    - Counter loaded with IMMORTAL_FRAMES.
    - rope_retract pulses in the next cycle.
    - If lives becomes 0: game_over=1, go to S_GAME_OVER.
  - present_f: counter loaded with IMMORTAL_FRAMES.
  - rope_f:
    - score += POINTS[type], saturating at all-ones.
    - rope_retract pulses.
    - If type != 0: split_type = type-1, split_req=1, go to S_SPLIT.
    - If type == 0: the ball vanishes; no split request.
  - Clear player_f, present_f and rope_f.
- immortal = (counter != 0), registered.
- S_SPLIT:
  - split_req and split_type held stable until split_ack is sampled high. split_req falls the cycle after the ack; return to S_RUN.
  - While in S_SPLIT, startOfFrame still processes the counter, the player hit and the present.
  - rope_f is not consumed or cleared in S_SPLIT; it is evaluated at the first startOfFrame after returning to S_RUN.
- S_GAME_OVER:
  - All outputs frozen; split_req=0; inputs ignored.
  - Exit only via resetN.
- Player hit and present in the same frame: the hit is processed first, then the present reloads the counter (same value).
- rope_retract is never wider than one cycle, even when a player hit and a rope hit occur in the same frame.
- An asynchronous reset mid-handshake drops split_req immediately.

Optional Feature:
- Macro EXTRA_LIFE_PRESENT_EN.
- Defined: a present adds one life, saturating at 3, and does not load the immortality counter.
- Undefined: a present grants the IMMORTAL_FRAMES window as described above.

Decomposition:
- Package collision_pkg:
  - ball_type_t (2-bit).
  - POINTS array: type0=10, type1=20, type2=50, type3=100.
  - State enum {S_RUN, S_SPLIT, S_GAME_OVER}.
  - LIVES_MAX=3.
- One sub-module, immortal_timer: loadable down-counter ticking on startOfFrame, with a nonzero flag output.

Test Plan:
- col_rope_ball pulsed 5 cycles in one frame with type 2, then startOfFrame -> score=50 and one rope_retract pulse. split_req=1 with split_type=1, held for 10 cycles until split_ack -> split_req low the next cycle.
- Rope hit type 0 -> score+=10; split_req never asserts.
- col_player_ball at lives=3, then startOfFrame -> lives=2 and immortal=1. Repeat the hit the next frame -> lives stays 2. immortal drops after exactly 120 startOfFrame pulses.
- Three non-immortal hits -> lives=0, game_over=1. Further collisions change nothing until resetN.
- Rope hit in the same cycle as startOfFrame -> score unchanged on that pulse; updated at the next pulse.
- resetN low while split_req=1 -> split_req=0 immediately and all outputs at their reset values. With EXTRA_LIFE_PRESENT_EN defined, a present at lives=2 -> lives=3 and immortal=0.

Source files
------------

// File: rtl/collision_responder_pkg.sv
// collision_pkg: shared types, state encoding and score table for collision_responder.
package collision_pkg;

    typedef logic [1:0] ball_type_t;

    typedef enum logic [1:0] {S_RUN, S_SPLIT, S_GAME_OVER} state_t;

    localparam logic [1:0] LIVES_MAX = 2'd3;

    localparam logic [7:0] POINTS [4] = '{8'd10, 8'd20, 8'd50, 8'd100};

endpackage

// File: rtl/collision_responder_immortal_timer.sv
// immortal_timer: loadable down-counter ticking once per frame; nonzero flags an active window.
module immortal_timer #(
    parameter int FRAMES = 120
) (
    input  logic clk,
    input  logic resetN,
    input  logic tick,
    input  logic load,
    output logic nonzero
);
    localparam int W = $clog2(FRAMES + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? W'(FRAMES) : (tick && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) cnt_q <= '0;
        else         cnt_q <= cnt_d;

    assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/collision_responder.sv
// collision_responder: latches per-frame collision levels and applies lives/score/immortality/split effects on startOfFrame.
// Build option EXTRA_LIFE_PRESENT_EN: a present grants one life (max 3) instead of an immortality window.
module collision_responder
    import collision_pkg::*;
#(
    parameter int IMMORTAL_FRAMES = 120,
    parameter int LIVES_INIT      = 3,
    parameter int SCORE_W         = 16
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               col_player_ball,
    input  logic               col_rope_ball,
    input  logic [1:0]         col_ball_type,
    input  logic               col_present,
    input  logic               split_ack,
    output logic               split_req,
    output logic [1:0]         split_type,
    output logic               rope_retract,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               immortal,
    output logic               game_over
);
    state_t             state_q, state_d;
    logic               player_f_q, player_f_d, rope_f_q, rope_f_d, present_f_q, present_f_d;
    ball_type_t         rope_type_q, rope_type_d;
    logic               split_req_q, split_req_d;
    ball_type_t         split_type_q, split_type_d;
    logic               rope_retract_q, rope_retract_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic               game_over_q, game_over_d;
    logic               eval, hit, rope_keep, tmr_load, immortal_w;
    logic [SCORE_W:0]   score_sum;

    immortal_timer #(.FRAMES(IMMORTAL_FRAMES)) u_timer (
        .clk     (clk),
        .resetN  (resetN),
        .tick    (eval),
        .load    (tmr_load),
        .nonzero (immortal_w)
    );

    always_comb begin
        state_d        = state_q;
        player_f_d     = player_f_q;
        rope_f_d       = rope_f_q;
        present_f_d    = present_f_q;
        rope_type_d    = rope_type_q;
        split_req_d    = split_req_q;
        split_type_d   = split_type_q;
        rope_retract_d = 1'b0;
        score_d        = score_q;
        lives_d        = lives_q;
        game_over_d    = game_over_q;
        eval           = startOfFrame && state_q != S_GAME_OVER;
        hit            = eval && player_f_q && !immortal_w;
        tmr_load       = hit;
        score_sum      = {1'b0, score_q} + (SCORE_W + 1)'(POINTS[rope_type_q]);
        // rope hits survive the frame boundary while a split is still pending
        rope_keep      = rope_f_q && !(eval && state_q == S_RUN);
        if (state_q != S_GAME_OVER) begin
            player_f_d  = (player_f_q && !eval) || col_player_ball;
            present_f_d = (present_f_q && !eval) || col_present;
            rope_f_d    = rope_keep || col_rope_ball;
            rope_type_d = (col_rope_ball && !rope_keep) ? col_ball_type : rope_type_q;
        end
        if (hit) begin
            lives_d        = lives_q - 2'd1;
            rope_retract_d = 1'b1;
            if (lives_d == 2'd0) begin
                game_over_d = 1'b1;
                split_req_d = 1'b0;
                state_d     = S_GAME_OVER;
            end
        end
        if (eval && present_f_q && !game_over_d) begin
`ifdef EXTRA_LIFE_PRESENT_EN
            lives_d = (lives_d < LIVES_MAX) ? lives_d + 2'd1 : lives_d;
`else
            tmr_load = 1'b1;
`endif
        end
        if (eval && state_q == S_RUN && rope_f_q && !game_over_d) begin
            score_d        = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            rope_retract_d = 1'b1;
            if (rope_type_q != 2'd0) begin
                split_type_d = rope_type_q - 2'd1;
                split_req_d  = 1'b1;
                state_d      = S_SPLIT;
            end
        end
        if (state_q == S_SPLIT && split_ack && !game_over_d) begin
            split_req_d = 1'b0;
            state_d     = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= S_RUN;
            player_f_q     <= 1'b0;
            rope_f_q       <= 1'b0;
            present_f_q    <= 1'b0;
            rope_type_q    <= 2'd0;
            split_req_q    <= 1'b0;
            split_type_q   <= 2'd0;
            rope_retract_q <= 1'b0;
            score_q        <= '0;
            lives_q        <= 2'(LIVES_INIT);
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            player_f_q     <= player_f_d;
            rope_f_q       <= rope_f_d;
            present_f_q    <= present_f_d;
            rope_type_q    <= rope_type_d;
            split_req_q    <= split_req_d;
            split_type_q   <= split_type_d;
            rope_retract_q <= rope_retract_d;
            score_q        <= score_d;
            lives_q        <= lives_d;
            game_over_q    <= game_over_d;
        end
    end

    assign split_req    = split_req_q;
    assign split_type   = split_type_q;
    assign rope_retract = rope_retract_q;
    assign score        = score_q;
    assign lives        = lives_q;
    assign immortal     = immortal_w;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_collision_responder.sv
// tb_collision_responder: directed self-checking bench for collision_responder.
module tb_collision_responder;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        col_player_ball = 1'b0;
    logic        col_rope_ball = 1'b0;
    logic [1:0]  col_ball_type = 2'd0;
    logic        col_present = 1'b0;
    logic        split_ack = 1'b0;
    logic        split_req;
    logic [1:0]  split_type;
    logic        rope_retract;
    logic [15:0] score;
    logic [1:0]  lives;
    logic        immortal;
    logic        game_over;

    int checks = 0;
    int errors = 0;
    int exp_lives;

    collision_responder dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .col_player_ball (col_player_ball),
        .col_rope_ball   (col_rope_ball),
        .col_ball_type   (col_ball_type),
        .col_present     (col_present),
        .split_ack       (split_ack),
        .split_req       (split_req),
        .split_type      (split_type),
        .rope_retract    (rope_retract),
        .score           (score),
        .lives           (lives),
        .immortal        (immortal),
        .game_over       (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame();
            tick();
        end
    endtask

    task automatic rope_hit(input logic [1:0] t);
        col_rope_ball = 1'b1;
        col_ball_type = t;
        tick();
        col_rope_ball = 1'b0;
    endtask

    task automatic player_hit();
        col_player_ball = 1'b1;
        tick();
        col_player_ball = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        check("rst_split_req", 32'(split_req), 0);
        check("rst_split_type", 32'(split_type), 0);
        check("rst_retract", 32'(rope_retract), 0);
        check("rst_score", 32'(score), 0);
        check("rst_lives", 32'(lives), 3);
        check("rst_immortal", 32'(immortal), 0);
        check("rst_game_over", 32'(game_over), 0);
        resetN = 1'b1;
        tick();

        // five rope pulses; later ones carry a different type that must be ignored
        for (int i = 0; i < 5; i++) begin
            rope_hit(i == 0 ? 2'd2 : 2'd3);
            tick();
        end
        frame();
        check("rope2_score", 32'(score), 50);
        check("rope2_retract", 32'(rope_retract), 1);
        check("rope2_split_req", 32'(split_req), 1);
        check("rope2_split_type", 32'(split_type), 1);
        tick();
        check("rope2_retract_1cyc", 32'(rope_retract), 0);
        for (int i = 0; i < 9; i++) tick();
        check("split_hold_req", 32'(split_req), 1);
        check("split_hold_type", 32'(split_type), 1);
        split_ack = 1'b1;
        tick();
        split_ack = 1'b0;
        check("split_after_ack", 32'(split_req), 0);

        rope_hit(2'd0);
        frame();
        check("rope0_score", 32'(score), 60);
        check("rope0_retract", 32'(rope_retract), 1);
        check("rope0_no_split", 32'(split_req), 0);
        tick();
        tick();
        check("rope0_no_split_later", 32'(split_req), 0);

        col_rope_ball = 1'b1;
        col_ball_type = 2'd0;
        frame();
        col_rope_ball = 1'b0;
        check("sof_rope_same_pulse", 32'(score), 60);
        tick();
        frame();
        check("sof_rope_next_pulse", 32'(score), 70);

        tick();
        player_hit();
        frame();
        check("hit_lives", 32'(lives), 2);
        check("hit_immortal", 32'(immortal), 1);
        check("hit_retract", 32'(rope_retract), 1);
        tick();
        player_hit();
        frame();
        check("hit_immortal_lives", 32'(lives), 2);
        check("hit_immortal_retract", 32'(rope_retract), 0);
        tick();
        frames(118);
        check("immortal_119", 32'(immortal), 1);
        frames(1);
        check("immortal_120", 32'(immortal), 0);

        col_present = 1'b1;
        tick();
        col_present = 1'b0;
        frame();
`ifdef EXTRA_LIFE_PRESENT_EN
        check("present_lives", 32'(lives), 3);
        check("present_immortal", 32'(immortal), 0);
        exp_lives = 3;
`else
        check("present_lives", 32'(lives), 2);
        check("present_immortal", 32'(immortal), 1);
        exp_lives = 2;
`endif
        tick();
        frames(120);
        check("present_window_end", 32'(immortal), 0);

        while (exp_lives > 0) begin
            player_hit();
            frame();
            exp_lives--;
            check("go_lives", 32'(lives), 32'(exp_lives));
            tick();
            if (exp_lives != 0) frames(120);
        end
        check("go_flag", 32'(game_over), 1);
        rope_hit(2'd2);
        player_hit();
        col_present = 1'b1;
        tick();
        col_present = 1'b0;
        frame();
        check("go_retract", 32'(rope_retract), 0);
        tick();
        check("go_score", 32'(score), 70);
        check("go_lives_frozen", 32'(lives), 0);
        check("go_split_req", 32'(split_req), 0);
        check("go_flag_sticky", 32'(game_over), 1);

        do_reset();
        check("post_go_lives", 32'(lives), 3);
        check("post_go_flag", 32'(game_over), 0);

        for (int i = 0; i < 656; i++) begin
            rope_hit(2'd3);
            frame();
            split_ack = 1'b1;
            tick();
            split_ack = 1'b0;
            if (i == 654) check("score_65500", 32'(score), 65500);
        end
        check("score_saturated", 32'(score), 65535);

        do_reset();
        rope_hit(2'd3);
        frame();
        check("async_pre_req", 32'(split_req), 1);
        check("async_pre_type", 32'(split_type), 2);
        check("async_pre_score", 32'(score), 100);
        #2 resetN = 1'b0;
        #1;
        check("async_split_req", 32'(split_req), 0);
        check("async_split_type", 32'(split_type), 0);
        check("async_score", 32'(score), 0);
        check("async_lives", 32'(lives), 3);
        check("async_immortal", 32'(immortal), 0);
        check("async_game_over", 32'(game_over), 0);
        check("async_retract", 32'(rope_retract), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
